fir_poly_sum: RTL and testbench



---
 rtl/fir_poly_sum.sv | 198 +++++++++++++++++++
 tb/tb_fir_poly_sum.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fir_poly_sum.sv
// Output stage behind the polyphase FIR banks: accumulates M branch partials per sample,
// rounds/saturates the sum and queues it in a 2-entry FIFO with sticky drop/framing flags.
module fir_poly_sum #(
    parameter int M            = 20,
    parameter int IN_WIDTH     = 35,
    parameter int OUTPUT_WIDTH = 24,
    parameter int DROP_BITS    = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic signed [IN_WIDTH-1:0]     din,
    input  logic                           din_valid,
    input  logic                           din_last,
    output logic signed [OUTPUT_WIDTH-1:0] dout,
    output logic                           dout_valid,
    input  logic                           dout_ready,
    input  logic                           clr_flags,
    output logic                           ovf,
    output logic                           err
);

    localparam int M_LOG2    = $clog2(M);
    localparam int ACC_WIDTH = IN_WIDTH + M_LOG2;
    localparam int RW        = ACC_WIDTH + 1;

    localparam logic [M_LOG2-1:0]    LAST_BEAT = M_LOG2'(M - 1);
    localparam logic signed [RW-1:0] HALF      = RW'(1) <<< (DROP_BITS - 1);
    localparam logic signed [RW-1:0] SAT_MAX   = (RW'(1) <<< (OUTPUT_WIDTH - 1)) - RW'(1);
    localparam logic signed [RW-1:0] SAT_MIN   = -(RW'(1) <<< (OUTPUT_WIDTH - 1));

    // ------------------------------------------------------------------
    // Beat accumulator
    // ------------------------------------------------------------------
    logic [M_LOG2-1:0]           count_reg;
    logic signed [ACC_WIDTH-1:0] acc_reg;
    logic                        done_reg;

    logic signed [ACC_WIDTH-1:0] din_ext;
    logic signed [ACC_WIDTH-1:0] acc_base;
    logic signed [ACC_WIDTH-1:0] acc_sum;
    logic                        is_last_beat;
    logic                        frame_ok;
    logic                        frame_err;

    always_comb begin
        din_ext      = {{M_LOG2{din[IN_WIDTH-1]}}, din};
        acc_base     = (count_reg == '0) ? '0 : acc_reg;
        acc_sum      = acc_base + din_ext;
        is_last_beat = (count_reg == LAST_BEAT);
        frame_ok     = din_valid && din_last && is_last_beat;
        frame_err    = din_valid && (din_last != is_last_beat);
    end

    // The final sum stays in acc_reg for one cycle after completion; the round
    // stage picks it up from there, so no separate sum register is needed.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
            acc_reg   <= '0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= frame_ok;
            if (frame_ok) begin
                acc_reg   <= acc_sum;
                count_reg <= '0;
            end else if (frame_err) begin
                acc_reg   <= '0;
                count_reg <= '0;
            end else if (din_valid) begin
                acc_reg   <= acc_sum;
                count_reg <= count_reg + M_LOG2'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Round half up, then saturate
    // ------------------------------------------------------------------
    logic signed [RW-1:0]           sum_ext;
    logic signed [RW-1:0]           rnd_add;
    logic signed [RW-1:0]           rnd_shift;
    logic signed [OUTPUT_WIDTH-1:0] rnd_sat;
    logic                           rnd_valid_reg;
    logic signed [OUTPUT_WIDTH-1:0] rnd_data_reg;

    always_comb begin
        sum_ext   = {acc_reg[ACC_WIDTH-1], acc_reg};
        rnd_add   = sum_ext + HALF;
        rnd_shift = rnd_add >>> DROP_BITS;
        if (rnd_shift > SAT_MAX) begin
            rnd_sat = {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
        end else if (rnd_shift < SAT_MIN) begin
            rnd_sat = {1'b1, {(OUTPUT_WIDTH-1){1'b0}}};
        end else begin
            rnd_sat = rnd_shift[OUTPUT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rnd_valid_reg <= 1'b0;
            rnd_data_reg  <= '0;
        end else begin
            rnd_valid_reg <= done_reg;
            rnd_data_reg  <= rnd_sat;
        end
    end

    // ------------------------------------------------------------------
    // 2-entry output FIFO; slot 0 is the head and drives dout directly
    // ------------------------------------------------------------------
    logic [1:0]                     fifo_count_reg;
    logic [1:0]                     fifo_count_next;
    logic signed [OUTPUT_WIDTH-1:0] fifo_mem_reg  [2];
    logic signed [OUTPUT_WIDTH-1:0] fifo_mem_next [2];
    logic                           dout_valid_reg;
    logic                           pop;
    logic                           push_ok;
    logic                           drop;

    always_comb begin
        pop     = dout_valid_reg && dout_ready;
        push_ok = rnd_valid_reg && ((fifo_count_reg != 2'd2) || pop);
        drop    = rnd_valid_reg && !push_ok;

        fifo_count_next  = fifo_count_reg;
        fifo_mem_next[0] = fifo_mem_reg[0];
        fifo_mem_next[1] = fifo_mem_reg[1];

        if (push_ok && !pop) begin
            fifo_count_next = fifo_count_reg + 2'd1;
        end else if (!push_ok && pop) begin
            fifo_count_next = fifo_count_reg - 2'd1;
        end

        if (pop) begin
            if (fifo_count_reg == 2'd2) begin
                fifo_mem_next[0] = fifo_mem_reg[1];
                if (push_ok) begin
                    fifo_mem_next[1] = rnd_data_reg;
                end
            end else if (push_ok) begin
                fifo_mem_next[0] = rnd_data_reg;
            end
        end else if (push_ok) begin
            if (fifo_count_reg == 2'd0) begin
                fifo_mem_next[0] = rnd_data_reg;
            end else begin
                fifo_mem_next[1] = rnd_data_reg;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fifo_slot
            always_ff @(posedge clk) begin
                if (rst) begin
                    fifo_mem_reg[gi] <= '0;
                end else begin
                    fifo_mem_reg[gi] <= fifo_mem_next[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_count_reg <= 2'd0;
            dout_valid_reg <= 1'b0;
        end else begin
            fifo_count_reg <= fifo_count_next;
            dout_valid_reg <= (fifo_count_next != 2'd0);
        end
    end

    assign dout       = fifo_mem_reg[0];
    assign dout_valid = dout_valid_reg;

    // ------------------------------------------------------------------
    // Sticky flags: a set event in the clearing cycle wins
    // ------------------------------------------------------------------
    logic ovf_reg;
    logic err_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_reg <= 1'b0;
            err_reg <= 1'b0;
        end else begin
            ovf_reg <= drop      || (ovf_reg && !clr_flags);
            err_reg <= frame_err || (err_reg && !clr_flags);
        end
    end

    assign ovf = ovf_reg;
    assign err = err_reg;

endmodule

// File: tb/tb_fir_poly_sum.sv
// Directed bench for fir_poly_sum with M=4, IN_WIDTH=8, OUTPUT_WIDTH=6, DROP_BITS=2.
module tb_fir_poly_sum;

    logic              clk = 1'b0;
    logic              rst;
    logic signed [7:0] din;
    logic              din_valid;
    logic              din_last;
    logic signed [5:0] dout;
    logic              dout_valid;
    logic              dout_ready;
    logic              clr_flags;
    logic              ovf;
    logic              err;

    int n_cmp  = 0;
    int n_fail = 0;

    fir_poly_sum #(
        .M(4), .IN_WIDTH(8), .OUTPUT_WIDTH(6), .DROP_BITS(2)
    ) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_last(din_last),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .clr_flags(clr_flags), .ovf(ovf), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
        $display("check %-16s observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic beat(input int v, input bit last);
        din       = 8'(v);
        din_valid = 1'b1;
        din_last  = last;
        tick();
        din_valid = 1'b0;
        din_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        din_valid = 1'b0;
        din_last  = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic frame(input int a, input int b, input int c, input int d);
        beat(a, 1'b0);
        beat(b, 1'b0);
        beat(c, 1'b0);
        beat(d, 1'b1);
    endtask

    // Waits (bounded) for a sample, checks it, then lets it pop when ready=1.
    task automatic expect_sample(input string tag, input int exp);
        int waited = 0;
        while (!dout_valid && waited < 10) begin
            tick();
            waited++;
        end
        check({tag, "_valid"}, int'(dout_valid), 1);
        check(tag, int'(dout), exp);
        tick();
    endtask

    task automatic expect_silence(input string tag, input int n);
        int seen = 0;
        for (int i = 0; i < n; i++) begin
            if (dout_valid) seen++;
            tick();
        end
        check(tag, seen, 0);
    endtask

    initial begin
        rst = 1'b1; din = '0; din_valid = 1'b0; din_last = 1'b0;
        dout_ready = 1'b1; clr_flags = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("rst_valid", int'(dout_valid), 0);
        check("rst_dout", int'(dout), 0);
        check("rst_ovf", int'(ovf), 0);
        check("rst_err", int'(err), 0);

        // Basic sum with exact latency: valid appears 2 cycles after the last beat
        frame(1, 2, 3, 4);
        check("lat_t1", int'(dout_valid), 0);
        tick();
        check("lat_t2", int'(dout_valid), 0);
        tick();
        check("lat_valid", int'(dout_valid), 1);
        check("basic_3", int'(dout), 3);
        tick();
        check("basic_popped", int'(dout_valid), 0);

        frame(-1, -1, -1, -2);
        expect_sample("neg_m1", -1);

        // Saturation
        frame(127, 127, 127, 127);
        expect_sample("sat_pos", 31);
        frame(-128, -128, -128, -128);
        expect_sample("sat_neg", -32);
        check("sat_ovf", int'(ovf), 0);
        check("sat_err", int'(err), 0);

        // Backpressure: third sample dropped
        dout_ready = 1'b0;
        frame(1, 1, 1, 1);
        frame(2, 2, 2, 2);
        frame(3, 3, 3, 3);
        idle(4);
        check("bp_ovf", int'(ovf), 1);
        check("bp_valid", int'(dout_valid), 1);
        check("bp_head1", int'(dout), 1);
        idle(2);
        check("bp_hold", int'(dout), 1);
        dout_ready = 1'b1;
        tick();
        check("bp_valid2", int'(dout_valid), 1);
        check("bp_head2", int'(dout), 2);
        tick();
        check("bp_empty", int'(dout_valid), 0);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        check("bp_ovf_clr", int'(ovf), 0);

        // Early last on beat 3
        beat(1, 1'b0);
        beat(1, 1'b0);
        beat(1, 1'b1);
        check("early_err", int'(err), 1);
        expect_silence("early_noout", 6);
        frame(4, 4, 4, 4);
        expect_sample("after_err", 4);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        check("err_clr", int'(err), 0);

        // Missing last on beat 4
        beat(5, 1'b0);
        beat(5, 1'b0);
        beat(5, 1'b0);
        beat(5, 1'b0);
        check("nolast_err", int'(err), 1);
        expect_silence("nolast_noout", 6);

        // Gaps between beats
        beat(1, 1'b0);
        idle(1);
        beat(2, 1'b0);
        idle(2);
        beat(3, 1'b0);
        beat(4, 1'b1);
        expect_sample("gaps", 3);

        // Partial frame then reset
        beat(7, 1'b0);
        beat(7, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_silence("rst_noout", 6);
        check("rst2_ovf", int'(ovf), 0);
        check("rst2_err", int'(err), 0);
        frame(1, 2, 3, 4);
        expect_sample("post_rst", 3);
        check("final_err", int'(err), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
